// File: rtl/mips_pkg.sv
// Shared definitions for the mips32 pipeline: reset vector, NOP encoding,
// fetch FSM states and the fetch buffer entry layout.
package mips_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Instruction addresses are word aligned; redirect targets are coerced to that.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response channel between the fetch stage
// (master) and the instruction memory (slave).
interface if_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch.sv
// mips32 instruction-fetch stage: owns the PC, keeps one imem request in
// flight, buffers a response across a stall and drops responses made stale by a redirect.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        stall_i,
    input  logic              flush_i,
    input  logic [31:0]       flush_target_i,
    input  logic              id_branch_taken_i,
    input  logic [31:0]       id_branch_target_i,
    if_fetch_if.master        imem,
    output logic              if_valid_o,
    output logic [31:0]       if_pc_o,
    output logic [31:0]       if_pc_plus_4_o,
    output logic [31:0]       if_inst_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         kill_q, kill_d;
    fetch_entry_t buf_q, buf_d;

    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_inst_q, out_inst_d;

    logic         stall_fetch;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         accept;
    logic         deliver;
    fetch_entry_t deliver_entry;

    // Only stall[0] concerns fetch; the upper bits belong to later stages.
    logic         unused_stall;
    assign unused_stall = ^stall_i[3:1];

    assign stall_fetch = stall_i[0];
    assign redirect    = flush_i | id_branch_taken_i;
    assign redirect_pc = align_pc(flush_i ? flush_target_i : id_branch_target_i);

    assign imem.imem_req  = (state_q == F_REQ);
    assign imem.imem_addr = pc_q;
    assign accept         = (state_q == F_REQ) && imem.imem_ready;

    // Next-state, PC and buffer logic.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        kill_d        = kill_q;
        buf_d         = buf_q;
        deliver       = 1'b0;
        deliver_entry = '{pc: inflight_pc_q, inst: imem.imem_rdata};

        case (state_q)
            F_REQ: begin
                if (accept) begin
                    inflight_pc_d = pc_q;
                    state_d       = F_WAIT;
                    if (redirect) begin
                        kill_d = 1'b1;
                        pc_d   = redirect_pc;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else if (redirect) begin
                    pc_d = redirect_pc;
                end
            end

            F_WAIT: begin
                if (imem.imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = F_REQ;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else if (!kill_q) begin
                        if (!stall_fetch) begin
                            deliver = 1'b1;
                        end else begin
                            buf_d   = '{pc: inflight_pc_q, inst: imem.imem_rdata};
                            state_d = F_HOLD;
                        end
                    end
                end else if (redirect) begin
                    // The in-flight response is now stale; remember to drop it.
                    kill_d = 1'b1;
                    pc_d   = redirect_pc;
                end
            end

            F_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = F_REQ;
                end else if (!stall_fetch) begin
                    deliver       = 1'b1;
                    deliver_entry = buf_q;
                    state_d       = F_REQ;
                end
            end

            default: begin
                state_d = F_REQ;
            end
        endcase
    end

    // Output register: flush clears regardless of stall; stall freezes everything else.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
            out_inst_d  = INST_NOP;
        end else if (!stall_fetch) begin
            if (deliver) begin
                out_valid_d = 1'b1;
                out_pc_d    = deliver_entry.pc;
                out_inst_d  = deliver_entry.inst;
            end else begin
                out_valid_d = 1'b0;
                out_inst_d  = INST_NOP;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= F_REQ;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_inst_q  <= INST_NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
        end
    end

    // NOTE: payload registers carry no reset; they are only read after the FSM has written them.
    always_ff @(posedge clk) begin
        inflight_pc_q <= inflight_pc_d;
        buf_q         <= buf_d;
    end

    assign if_valid_o     = out_valid_q;
    assign if_pc_o        = out_pc_q;
    assign if_pc_plus_4_o = out_pc_q + PC_STEP;
    assign if_inst_o      = out_inst_q;

endmodule
